// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits and a clear-sweep FSM.
// Optional write-to-read forwarding is enabled with `define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                        state;
    logic [ADDR_W-1:0]             cnt;
    logic [NREGS-1:0][DATA_W-1:0]  regs;
    logic [NREGS-1:0]              pend;
    logic                          wr_ok;
    logic                          claim_ok;

    // R0 writes/claims are dropped so storage for R0 never leaves zero
    assign wr_ok    = wr_en    && (state == IDLE) && !((ZERO_R0 != 0) && (wr_addr    == '0));
    assign claim_ok = claim_en && (state == IDLE) && !((ZERO_R0 != 0) && (claim_addr == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            regs     <= '0;
            pend     <= '0;
            cnt      <= '0;
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        regs[wr_addr] <= wr_data;
                        pend[wr_addr] <= 1'b0;
                    end
                    // claim placed after write so a same-index claim wins
                    if (claim_ok)
                        pend[claim_addr] <= 1'b1;
                    if (clr_req) begin
                        state    <= SWEEP;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    regs[cnt] <= '0;
                    pend[cnt] <= 1'b0;
                    cnt       <= cnt + ADDR_W'(1);
                    if (cnt == ADDR_W'(NREGS - 1)) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    logic [1:0][ADDR_W-1:0] ra;
    logic [1:0][DATA_W-1:0] rd;
    logic [1:0]             rb;

    assign ra = {rs2_addr, rs1_addr};

    always_comb begin
        rd = '0;
        rb = '0;
        for (int p = 0; p < 2; p++) begin
            if ((ZERO_R0 != 0) && (ra[p] == '0)) begin
                rd[p] = '0;
                rb[p] = 1'b0;
            end else begin
                rd[p] = regs[ra[p]];
                rb[p] = pend[ra[p]];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (wr_addr == ra[p])) begin
                    rd[p] = wr_data;
                    rb[p] = 1'b0;
                end
`endif
            end
        end
    end

    assign rs1_data = rd[0];
    assign rs2_data = rd[1];
    assign rs1_busy = rb[0];
    assign rs2_busy = rb[1];

endmodule
